// File: rtl/iomem_timer_if.sv
// PicoSoC iomem bus bundle: request and write fields from the master,
// a one-cycle ready pulse and read data from the slave.
interface iomem_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_timer.sv
// Memory-mapped down-counting timer with auto-reload and level irq on the iomem bus.
// Define IOMEM_TIMER_PRESCALER_EN to build the 8-bit prescaler (CTRL[15:8]).
module iomem_timer #(
  parameter logic [7:0] ADDR_HI = 8'h04
) (
  input  logic          clk,
  input  logic          resetn,
  iomem_timer_if.slave  bus,
  output logic          irq
);
  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t      state_reg, state_next;
  logic        en_reg, en_next, auto_reg, auto_next, ie_reg, ie_next;
  logic        exp_reg, exp_next, irq_reg;
  logic [31:0] load_reg, load_next, count_reg, count_next;
  logic [31:0] rdata_reg, rdata_next, rd_mux;
  logic [31:0] load_wr, count_wr;
  logic [7:0]  presc_val;
  logic        acc, wr, wr_ctrl, wr_load, wr_count, wr_status, tick, expire;
  logic [1:0]  sel;
  logic        unused_addr;

  // Ack only from idle so a held valid is answered every second cycle.
  assign acc       = bus.iomem_valid && (bus.iomem_addr[31:24] == ADDR_HI) && (state_reg == ST_IDLE);
  assign sel       = bus.iomem_addr[3:2];
  assign wr        = |bus.iomem_wstrb;
  assign wr_ctrl   = acc && wr && (sel == 2'd0);
  assign wr_load   = acc && wr && (sel == 2'd1);
  assign wr_count  = acc && wr && (sel == 2'd2);
  assign wr_status = acc && wr && (sel == 2'd3);
  assign unused_addr = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign load_wr[gi*8 +: 8]  = bus.iomem_wstrb[gi] ? bus.iomem_wdata[gi*8 +: 8] : load_reg[gi*8 +: 8];
      assign count_wr[gi*8 +: 8] = bus.iomem_wstrb[gi] ? bus.iomem_wdata[gi*8 +: 8] : count_reg[gi*8 +: 8];
    end
  endgenerate

`ifdef IOMEM_TIMER_PRESCALER_EN
  logic [7:0] presc_reg, presc_next, pcnt_reg, pcnt_next;

  assign presc_val = presc_reg;
  assign tick      = en_reg && (pcnt_reg == presc_reg);

  always_comb begin
    presc_next = presc_reg;
    if (wr_ctrl && bus.iomem_wstrb[1])
      presc_next = bus.iomem_wdata[15:8];
    pcnt_next = pcnt_reg + 8'd1;
    if (!en_reg || wr_ctrl || tick)
      pcnt_next = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_reg <= 8'd0;
      pcnt_reg  <= 8'd0;
    end else begin
      presc_reg <= presc_next;
      pcnt_reg  <= pcnt_next;
    end
  end
`else
  assign presc_val = 8'd0;
  assign tick      = en_reg;
`endif

  assign expire = tick && (count_reg == 32'd0);

  always_comb begin
    case (sel)
      2'd0:    rd_mux = {16'd0, presc_val, 5'd0, ie_reg, auto_reg, en_reg};
      2'd1:    rd_mux = load_reg;
      2'd2:    rd_mux = count_reg;
      default: rd_mux = {31'd0, exp_reg};
    endcase
  end

  always_comb begin
    state_next = ST_IDLE;
    if (acc)
      state_next = ST_ACK;
    rdata_next = acc ? rd_mux : 32'd0;
    en_next    = en_reg;
    auto_next  = auto_reg;
    ie_next    = ie_reg;
    exp_next   = exp_reg;
    load_next  = wr_load ? load_wr : load_reg;
    count_next = count_reg;

    if (tick) begin
      if (count_reg == 32'd0) begin
        if (auto_reg)
          count_next = load_reg;
        else
          en_next = 1'b0;
      end else begin
        count_next = count_reg - 32'd1;
      end
    end
    // Bus writes are applied after the tick so they take precedence.
    if (wr_count)
      count_next = count_wr;
    if (wr_ctrl && bus.iomem_wstrb[0]) begin
      en_next   = bus.iomem_wdata[0];
      auto_next = bus.iomem_wdata[1];
      ie_next   = bus.iomem_wdata[2];
    end
    if (wr_status && bus.iomem_wstrb[0] && bus.iomem_wdata[0])
      exp_next = 1'b0;
    if (expire)
      exp_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      rdata_reg <= 32'd0;
      en_reg    <= 1'b0;
      auto_reg  <= 1'b0;
      ie_reg    <= 1'b0;
      exp_reg   <= 1'b0;
      irq_reg   <= 1'b0;
      load_reg  <= 32'd0;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      en_reg    <= en_next;
      auto_reg  <= auto_next;
      ie_reg    <= ie_next;
      exp_reg   <= exp_next;
      irq_reg   <= exp_reg & ie_reg;
      load_reg  <= load_next;
      count_reg <= count_next;
    end
  end

  assign bus.iomem_ready = (state_reg == ST_ACK);
  assign bus.iomem_rdata = rdata_reg;
  assign irq             = irq_reg;
endmodule

// File: tb/tb_iomem_timer.sv
// Scoreboarded bench for iomem_timer: bus accesses queue their expected read data,
// a negedge monitor compares on every ready pulse; irq timing is checked directly.
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0400_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_LOAD = BASE + 32'h4;
  localparam logic [31:0] A_COUNT = BASE + 32'h8, A_STAT = BASE + 32'hC;

  logic clk = 1'b0;
  logic resetn;
  logic irq;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0, r1, r2;

  iomem_timer_if bus ();

  iomem_timer #(.ADDR_HI(8'h04)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    bit          care;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.iomem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 required=0 addr=%h", bus.iomem_addr);
      end else begin
        e = sb.pop_front();
        if (e.care)
          check($sformatf("rdata@%h", e.addr), bus.iomem_rdata, e.rdata);
        else
          $display("txn  addr=%h rdata=%h (unchecked)", e.addr, bus.iomem_rdata);
      end
    end
  end

  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit care);
    bit got = 1'b0;
    sb.push_back('{exp_rd, care, addr});
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.iomem_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'd0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout addr=%h actual=0 required=1", addr);
      void'(sb.pop_back());
    end
  endtask

  task automatic wait_level(input logic lvl, input string name, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (irq === lvl) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s irq_timeout actual=%b required=%b", name, irq, lvl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetn          = 1'b0;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'd0;
    bus.iomem_wstrb = 4'd0;
    bus.iomem_wdata = 32'd0;
    idle(3);
    check("reset_ready", {31'd0, bus.iomem_ready}, 32'd0);
    check("reset_rdata", bus.iomem_rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    idle(1);

    access(A_CTRL,  4'h0, 32'd0, 32'd0, 1);
    access(A_LOAD,  4'h0, 32'd0, 32'd0, 1);
    access(A_COUNT, 4'h0, 32'd0, 32'd0, 1);
    access(A_STAT,  4'h0, 32'd0, 32'd0, 1);

    // Auto-reload, LOAD=4, PRESC=0: EXP every 5 cycles.
    access(A_LOAD, 4'hF, 32'd4, 32'd0, 1);
    access(A_CTRL, 4'hF, 32'h7, 32'd0, 1);
    c0 = cyc;
    wait_level(1'b1, "t1_rise", r1);
    check("t1_first_rise_delay", r1 - c0, 32'd2);
    access(A_STAT, 4'hF, 32'd1, 32'd1, 1);
    check("t1_irq_still_high", {31'd0, irq}, 32'd1);
    idle(1);
    check("t1_irq_dropped", {31'd0, irq}, 32'd0);
    wait_level(1'b1, "t1_rise2", r2);
    check("t1_period", r2 - r1, 32'd5);
    access(A_CTRL, 4'hF, 32'd0, 32'h7, 1);
    access(A_STAT, 4'hF, 32'd1, 32'd1, 1);

    // One-shot from COUNT=3.
    access(A_COUNT, 4'hF, 32'd3, 32'd0, 0);
    access(A_CTRL,  4'hF, 32'h5, 32'd0, 1);
    c0 = cyc;
    wait_level(1'b1, "t2_rise", r1);
    check("t2_oneshot_delay", r1 - c0, 32'd5);
    access(A_CTRL,  4'h0, 32'd0, 32'h4, 1);
    access(A_COUNT, 4'h0, 32'd0, 32'd0, 1);
    idle(3);
    access(A_COUNT, 4'h0, 32'd0, 32'd0, 1);
    access(A_STAT,  4'hF, 32'd1, 32'd1, 1);

    // W1C landing on the expiry edge: expiry wins.
    access(A_COUNT, 4'hF, 32'd3, 32'd0, 1);
    access(A_CTRL,  4'hF, 32'h5, 32'h4, 1);
    idle(3);
    access(A_STAT, 4'hF, 32'd1, 32'd0, 1);
    idle(1);
    check("t2b_irq_after_collision", {31'd0, irq}, 32'd1);
    access(A_STAT, 4'h0, 32'd0, 32'd1, 1);
    access(A_STAT, 4'hF, 32'd1, 32'd1, 1);

    // COUNT write while ticking every cycle: written value wins, then one tick later.
    access(A_COUNT, 4'hF, 32'h10, 32'd0, 1);
    access(A_CTRL,  4'hF, 32'h1, 32'h4, 1);
    access(A_COUNT, 4'hF, 32'h100, 32'd0, 0);
    access(A_COUNT, 4'h0, 32'd0, 32'h0FF, 1);
    access(A_CTRL,  4'hF, 32'd0, 32'h1, 1);

    // Prescaler: PRESC=3, LOAD=1, AUTO.
    access(A_LOAD,  4'hF, 32'd1, 32'd4, 1);
    access(A_COUNT, 4'hF, 32'd0, 32'd0, 0);
    access(A_CTRL,  4'hF, 32'h307, 32'd0, 1);
    c0 = cyc;
    wait_level(1'b1, "t3_rise", r1);
`ifdef IOMEM_TIMER_PRESCALER_EN
    check("t3_first_rise_delay", r1 - c0, 32'd5);
`else
    check("t3_first_rise_delay", r1 - c0, 32'd2);
    idle(1);  // step off the expiry edge so the clear is not overridden
`endif
    access(A_STAT, 4'hF, 32'd1, 32'd1, 1);
    wait_level(1'b0, "t3_fall", r2);
    wait_level(1'b1, "t3_rise2", r2);
`ifdef IOMEM_TIMER_PRESCALER_EN
    check("t3_period", r2 - r1, 32'd8);
    access(A_CTRL, 4'h0, 32'd0, 32'h307, 1);
`else
    check("t3_two_periods", r2 - r1, 32'd4);
    access(A_CTRL, 4'h0, 32'd0, 32'h7, 1);
`endif
    access(A_CTRL, 4'hF, 32'd0, 32'd0, 0);
    access(A_STAT, 4'hF, 32'd1, 32'd0, 0);

    // Byte strobes and out-of-window access.
    access(A_LOAD, 4'hF, 32'd0, 32'd1, 1);
    access(A_LOAD, 4'b0010, 32'hAABBCCDD, 32'd0, 1);
    access(A_LOAD, 4'h0, 32'd0, 32'h0000CC00, 1);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0300_0004;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("foreign_no_ready_%0d", i), {31'd0, bus.iomem_ready}, 32'd0);
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'd0;
    access(A_LOAD, 4'h0, 32'd0, 32'h0000CC00, 1);
    check("final_irq_low", {31'd0, irq}, 32'd0);

    idle(3);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
